// File: rtl/shift_sub_divider_pkg.sv
// Shared definitions for the shift/subtract divider: FSM encoding and default sizes.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/shift_sub_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface shift_sub_divider_if
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/shift_sub_divider_div_step.sv
// One restoring-division iteration: shift {rem, quo} left and subtract the divisor if it fits.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH:0] i_acc,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [2*WIDTH:0] o_acc_c
);

    logic [WIDTH+1:0] w_hi;
    logic [WIDTH+1:0] w_diff;
    logic             w_fits;

    // w_hi is the shifted partial remainder; the extra MSB only serves as the borrow bit
    always_comb begin
        w_hi    = i_acc[2*WIDTH:WIDTH-1];
        w_diff  = w_hi - {2'b00, i_divisor};
        w_fits  = ~w_diff[WIDTH+1];
        o_acc_c = {(w_fits ? w_diff[WIDTH:0] : w_hi[WIDTH:0]), i_acc[WIDTH-2:0], w_fits};
    end

endmodule

// File: rtl/shift_sub_divider.sv
// Iterative restoring divider, one quotient bit per clock; operands captured on accept.
// Optional macro SIGNED_EN: two's-complement operands with a FIX state for sign correction.
module shift_sub_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input logic                clk,
    input logic                rst_n,
    shift_sub_divider_if.slave bus
);

    localparam int unsigned AW = 2*WIDTH + 1;

    state_e           r_state, w_state_nxt;
    logic [AW-1:0]    r_acc, w_acc_nxt, w_step;
    logic [WIDTH-1:0] r_divisor, w_divisor_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_quot, w_quot_nxt;
    logic [WIDTH-1:0] r_rem, w_rem_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_div_zero, w_div_zero_nxt;
    logic             r_zero, w_zero_nxt;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_zero_rem;

`ifdef SIGNED_EN
    logic             r_q_neg, w_q_neg_nxt;
    logic             r_r_neg, w_r_neg_nxt;
    logic [WIDTH-1:0] w_fix_q, w_fix_r;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    assign w_dvd_mag  = bus.dividend[WIDTH-1] ? negate(bus.dividend) : bus.dividend;
    assign w_dvs_mag  = bus.divisor[WIDTH-1]  ? negate(bus.divisor)  : bus.divisor;
    assign w_fix_q    = r_q_neg ? negate(r_acc[WIDTH-1:0])       : r_acc[WIDTH-1:0];
    assign w_fix_r    = r_r_neg ? negate(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];
    // divide-by-zero reports the original dividend, so undo the magnitude
    assign w_zero_rem = r_r_neg ? negate(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
`else
    assign w_dvd_mag  = bus.dividend;
    assign w_dvs_mag  = bus.divisor;
    assign w_zero_rem = r_acc[WIDTH-1:0];
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_acc     (r_acc),
        .i_divisor (r_divisor),
        .o_acc_c   (w_step)
    );

    // next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_acc_nxt      = r_acc;
        w_divisor_nxt  = r_divisor;
        w_cnt_nxt      = r_cnt;
        w_quot_nxt     = r_quot;
        w_rem_nxt      = r_rem;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_div_zero_nxt = r_div_zero;
        w_zero_nxt     = r_zero;
`ifdef SIGNED_EN
        w_q_neg_nxt    = r_q_neg;
        w_r_neg_nxt    = r_r_neg;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_acc_nxt     = {{(WIDTH+1){1'b0}}, w_dvd_mag};
                    w_divisor_nxt = w_dvs_mag;
                    w_zero_nxt    = (bus.divisor == '0);
                    w_cnt_nxt     = (bus.divisor == '0) ? '0 : CNT_W'(WIDTH);
                    w_busy_nxt    = 1'b1;
                    w_state_nxt   = ST_RUN;
`ifdef SIGNED_EN
                    w_q_neg_nxt   = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    w_r_neg_nxt   = bus.dividend[WIDTH-1];
`endif
                end
            end
            ST_RUN: begin
                // a zero divisor spends one idle slot here and skips every iteration
                if (r_zero) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_acc_nxt = w_step;
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
`ifdef SIGNED_EN
                        w_state_nxt = ST_FIX;
`else
                        w_state_nxt = ST_DONE;
`endif
                    end
                end
            end
`ifdef SIGNED_EN
            ST_FIX: begin
                w_acc_nxt   = {r_acc[2*WIDTH], w_fix_r, w_fix_q};
                w_state_nxt = ST_DONE;
            end
`endif
            ST_DONE: begin
                w_quot_nxt     = r_zero ? '1 : r_acc[WIDTH-1:0];
                w_rem_nxt      = r_zero ? w_zero_rem : r_acc[2*WIDTH-1:WIDTH];
                w_div_zero_nxt = r_zero;
                w_done_nxt     = 1'b1;
                w_busy_nxt     = 1'b0;
                w_state_nxt    = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_divisor  <= '0;
            r_cnt      <= '0;
            r_quot     <= '0;
            r_rem      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_zero     <= 1'b0;
`ifdef SIGNED_EN
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_acc      <= w_acc_nxt;
            r_divisor  <= w_divisor_nxt;
            r_cnt      <= w_cnt_nxt;
            r_quot     <= w_quot_nxt;
            r_rem      <= w_rem_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_div_zero <= w_div_zero_nxt;
            r_zero     <= w_zero_nxt;
`ifdef SIGNED_EN
            r_q_neg    <= w_q_neg_nxt;
            r_r_neg    <= w_r_neg_nxt;
`endif
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.div_zero  = r_div_zero;

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: vector table, corner sequences, random pairs.
module tb_shift_sub_divider;
    import div_pkg::*;

    localparam int unsigned W = DIV_WIDTH;
`ifdef SIGNED_EN
    localparam int LAT = W + 2;
`else
    localparam int LAT = W + 1;
`endif
    localparam int LAT_ZERO = 2;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } res_t;

    typedef struct {
        logic [W-1:0] n;
        logic [W-1:0] d;
        res_t         exp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_err    = 0;
    res_t sb[$];
    vec_t vecs[$];

    shift_sub_divider_if #(.WIDTH(W)) bus ();

    shift_sub_divider #(.WIDTH(W), .CNT_W(DIV_CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic res_t model(input logic [W-1:0] n, input logic [W-1:0] d);
        res_t e;
        e.dz = (d == '0);
        if (d == '0) begin
            e.q = '1;
            e.r = n;
        end
`ifdef SIGNED_EN
        else if (n == {1'b1, {(W-1){1'b0}}} && d == '1) begin
            e.q = n;
            e.r = '0;
        end else begin
            e.q = W'($signed(n) / $signed(d));
            e.r = W'($signed(n) % $signed(d));
        end
`else
        else begin
            e.q = n / d;
            e.r = n % d;
        end
`endif
        return e;
    endfunction

    task automatic compare_pop(input string name);
        res_t e;
        if (sb.size() == 0) begin
            chk({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({name, " quotient"},  32'(bus.quotient),  32'(e.q));
            chk({name, " remainder"}, 32'(bus.remainder), 32'(e.r));
            chk({name, " div_zero"},  32'(bus.div_zero),  32'(e.dz));
        end
    endtask

    // waits (bounded) for done, counting edges after the accept edge and busy dropouts
    task automatic wait_done(input string name, output int edges, output int busy_lo);
        edges   = 0;
        busy_lo = 0;
        while (bus.done !== 1'b1 && edges < 64) begin
            tick();
            edges++;
            if (bus.done !== 1'b1 && bus.busy !== 1'b1) busy_lo++;
        end
        if (bus.done !== 1'b1) begin
            chk({name, " timeout"}, 32'd0, 32'd1);
            edges = -1;
        end else begin
            compare_pop(name);
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] n, input logic [W-1:0] d,
                          input res_t e, output int edges, output int busy_lo);
        bus.start    = 1'b1;
        bus.dividend = n;
        bus.divisor  = d;
        sb.push_back(e);
        tick();
        bus.start = 1'b0;
        chk({name, " busy after accept"}, 32'(bus.busy), 32'd1);
        chk({name, " done one-cycle"},    32'(bus.done), 32'd0);
        wait_done(name, edges, busy_lo);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int   edges;
        int   busy_lo;
        res_t e;
        logic [W-1:0] n;
        logic [W-1:0] d;

`ifdef SIGNED_EN
        vecs.push_back('{W'(-100),   W'(7),    '{W'(-14),   W'(-2),  1'b0}});
        vecs.push_back('{W'(100),    W'(-7),   '{W'(-14),   W'(2),   1'b0}});
        vecs.push_back('{W'(-100),   W'(-7),   '{W'(14),    W'(-2),  1'b0}});
        vecs.push_back('{16'h8000,   16'hFFFF, '{16'h8000,  W'(0),   1'b0}});
        vecs.push_back('{W'(1234),   W'(0),    '{16'hFFFF,  W'(1234),1'b1}});
        vecs.push_back('{W'(10),     W'(3),    '{W'(3),     W'(1),   1'b0}});
        vecs.push_back('{W'(7),      W'(-9),   '{W'(0),     W'(7),   1'b0}});
        vecs.push_back('{W'(-5),     W'(0),    '{16'hFFFF,  W'(-5),  1'b1}});
`else
        vecs.push_back('{W'(100),    W'(7),    '{W'(14),    W'(2),   1'b0}});
        vecs.push_back('{W'(65535),  W'(1),    '{W'(65535), W'(0),   1'b0}});
        vecs.push_back('{W'(5),      W'(9),    '{W'(0),     W'(5),   1'b0}});
        vecs.push_back('{W'(1234),   W'(0),    '{16'hFFFF,  W'(1234),1'b1}});
        vecs.push_back('{W'(10),     W'(3),    '{W'(3),     W'(1),   1'b0}});
        vecs.push_back('{W'(0),      W'(5),    '{W'(0),     W'(0),   1'b0}});
        vecs.push_back('{W'(65535),  W'(65535),'{W'(1),     W'(0),   1'b0}});
        vecs.push_back('{W'(32768),  W'(3),    '{W'(10922), W'(2),   1'b0}});
        vecs.push_back('{W'(65534),  W'(65535),'{W'(0),     W'(65534),1'b0}});
        vecs.push_back('{W'(7),      W'(0),    '{16'hFFFF,  W'(7),   1'b1}});
`endif

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        chk("reset busy",      32'(bus.busy),      32'd0);
        chk("reset done",      32'(bus.done),      32'd0);
        chk("reset quotient",  32'(bus.quotient),  32'd0);
        chk("reset remainder", 32'(bus.remainder), 32'd0);
        chk("reset div_zero",  32'(bus.div_zero),  32'd0);
        rst_n = 1'b1;
        tick();

        // table: each op starts in the cycle right after the previous done
        for (int i = 0; i < vecs.size(); i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].d, vecs[i].exp, edges, busy_lo);
            chk($sformatf("vec%0d latency", i), 32'(edges), 32'(vecs[i].exp.dz ? LAT_ZERO : LAT));
            chk($sformatf("vec%0d busy gap", i), 32'(busy_lo), 32'd0);
            chk($sformatf("vec%0d busy at done", i), 32'(bus.busy), 32'd0);
        end

        // reset mid-run: result registers hold a div-by-zero result beforehand
        bus.start    = 1'b1;
        bus.dividend = W'(100);
        bus.divisor  = W'(7);
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("midreset busy",      32'(bus.busy),      32'd0);
        chk("midreset done",      32'(bus.done),      32'd0);
        chk("midreset quotient",  32'(bus.quotient),  32'd0);
        chk("midreset remainder", 32'(bus.remainder), 32'd0);
        chk("midreset div_zero",  32'(bus.div_zero),  32'd0);
        tick();
        chk("midreset held done", 32'(bus.done), 32'd0);
        rst_n = 1'b1;
        tick();
        run_op("post-reset 100/7", W'(100), W'(7), '{W'(14), W'(2), 1'b0}, edges, busy_lo);
        chk("post-reset latency",  32'(edges),   32'(LAT));
        chk("post-reset busy gap", 32'(busy_lo), 32'd0);
        tick();
        chk("done drops", 32'(bus.done), 32'd0);

        // start held high; operands changed while busy must not affect the running op
        bus.start    = 1'b1;
        bus.dividend = W'(200);
        bus.divisor  = W'(9);
        sb.push_back('{W'(22), W'(2), 1'b0});
        tick();
        bus.dividend = W'(50);
        bus.divisor  = W'(5);
        sb.push_back('{W'(10), W'(0), 1'b0});
        wait_done("held-start first", edges, busy_lo);
        chk("held-start first latency", 32'(edges), 32'(LAT));
        tick();
        chk("held-start re-accept busy", 32'(bus.busy), 32'd1);
        chk("held-start done pulse",     32'(bus.done), 32'd0);
        wait_done("held-start second", edges, busy_lo);
        chk("held-start second latency", 32'(edges), 32'(LAT));
        bus.start = 1'b0;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        tick();

        // random pairs against the reference model
        for (int i = 0; i < 150; i++) begin
            n = W'($urandom);
            case (i % 4)
                0:       d = W'($urandom_range(1, 15));
                1:       d = W'($urandom_range(0, 255));
                default: d = W'($urandom);
            endcase
            e = model(n, d);
            run_op($sformatf("rand%0d", i), n, d, e, edges, busy_lo);
`ifndef SIGNED_EN
            if (d != '0) begin
                chk($sformatf("rand%0d q*d+r", i),
                    32'(bus.quotient) * 32'(d) + 32'(bus.remainder), 32'(n));
                chk($sformatf("rand%0d r<d", i), 32'(bus.remainder < d), 32'd1);
            end
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
